sipo_rx: RTL and testbench



---
 rtl/sipo_pkg.sv | 15 +
 rtl/sipo_shreg.sv | 65 ++++++
 rtl/sipo_rx.sv | 136 +++++++++++++
 tb/tb_sipo_rx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out receiver.
package sipo_pkg;

    // Frame state: waiting for a start bit, or collecting bits of a frame.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bit counter width: must hold values 0..width inclusive.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Parameterized shift register plus bit counter for the SIPO receiver.
// load_first starts a new frame from an empty register (count=1).
// shift_en appends one bit. done flags the cycle that appends the last bit.
// sh_next is the post-shift value, so the caller can capture the final word
// on the same edge that samples the last bit.
module sipo_shreg
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             load_first,
    input  logic             s_data,
    output logic [WIDTH-1:0] sh_next,
    output logic             done
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [WIDTH-1:0] sh_r;
    logic [WIDTH-1:0] base_s;
    logic [CW-1:0]    count_r;

    // Next shift value: a new frame starts from an all-zero register.
    always_comb begin
        base_s = load_first ? {WIDTH{1'b0}} : sh_r;
        if (MSB_FIRST) begin
            sh_next = {base_s[WIDTH-2:0], s_data};
        end else begin
            sh_next = {s_data, base_s[WIDTH-1:1]};
        end
    end

    // A restart (load_first) takes priority, so it never counts as completion.
    always_comb begin
        done = shift_en && !load_first && (count_r == LAST_CNT);
    end

    // Shift register and bit counter; counter returns to 0 when a word completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r    <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (load_first) begin
            sh_r    <= sh_next;
            count_r <= ONE_CNT;
        end else if (shift_en) begin
            sh_r    <= sh_next;
            count_r <= done ? {CW{1'b0}} : (count_r + ONE_CNT);
        end else if (clear) begin
            sh_r    <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            sh_r    <= sh_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: reassembles WIDTH-bit words from a
// bit-serial stream and presents them on a registered valid/ready port.
// A completed word that finds the output still occupied is dropped and
// latches the sticky overrun flag.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             s_start,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             overrun
);

    state_e           state_r;
    state_e           state_next_s;
    logic             start_s;
    logic             shift_en_s;
    logic             clear_s;
    logic             done_s;
    logic [WIDTH-1:0] sh_next_s;

    logic [WIDTH-1:0] p_data_r;
    logic             p_valid_r;
    logic             busy_r;
    logic             overrun_r;
    logic [WIDTH-1:0] p_data_next_s;
    logic             p_valid_next_s;
    logic             overrun_next_s;
    logic             out_free_s;

    // Control strobes into the shift register: a start always begins a new frame.
    always_comb begin
        start_s    = s_valid && s_start;
        shift_en_s = s_valid && (state_r == SHIFT);
        clear_s    = (state_r == IDLE) && !start_s;
    end

    sipo_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (shift_en_s),
        .clear      (clear_s),
        .load_first (start_s),
        .s_data     (s_data),
        .sh_next    (sh_next_s),
        .done       (done_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: start (re)enters SHIFT, the last bit returns to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (start_s) begin
                    state_next_s = SHIFT;
                end else if (done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output logic: handshake, word capture on completion, sticky overrun.
    always_comb begin
        out_free_s     = !p_valid_r || p_ready;
        p_data_next_s  = p_data_r;
        overrun_next_s = overrun_r;
        if (p_valid_r && p_ready) begin
            p_valid_next_s = 1'b0;
        end else begin
            p_valid_next_s = p_valid_r;
        end
        if (done_s) begin
            if (out_free_s) begin
                p_data_next_s  = sh_next_s;
                p_valid_next_s = 1'b1;
            end else begin
                overrun_next_s = 1'b1;
            end
        end else begin
            p_data_next_s = p_data_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_data_r  <= {WIDTH{1'b0}};
            p_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            p_data_r  <= p_data_next_s;
            p_valid_r <= p_valid_next_s;
            busy_r    <= (state_next_s == SHIFT);
            overrun_r <= overrun_next_s;
        end
    end

    assign p_data  = p_data_r;
    assign p_valid = p_valid_r;
    assign busy    = busy_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx. Two instances (MSB-first and LSB-first)
// receive the same serial stream; expected words for each ordering are
// pushed to scoreboard queues when a frame is sent and popped on completion.
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid, s_data, s_start, p_ready;
    logic [3:0] m_pd, l_pd;
    logic       m_pv, l_pv, m_busy, l_busy, m_ov, l_ov;

    int total = 0;
    int bad   = 0;
    logic [3:0] q_m[$];
    logic [3:0] q_l[$];
    logic [3:0] exp_m, exp_l;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
        .s_start(s_start), .p_data(m_pd), .p_valid(m_pv), .p_ready(p_ready),
        .busy(m_busy), .overrun(m_ov)
    );

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
        .s_start(s_start), .p_data(l_pd), .p_valid(l_pv), .p_ready(p_ready),
        .busy(l_busy), .overrun(l_ov)
    );

    // {msb pv,busy,ov, lsb pv,busy,ov}
    function automatic logic [5:0] flags();
        return {m_pv, m_busy, m_ov, l_pv, l_busy, l_ov};
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] w);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = w[3-i];
        return r;
    endfunction

    // Drive one cycle of serial input, then wait until just after the edge.
    task automatic step(input logic v, input logic d, input logic st);
        s_valid = v; s_data = d; s_start = st;
        @(posedge clk); #1;
    endtask

    // seq[3] is sent first: MSB-first word equals seq, LSB-first is reversed.
    task automatic push_word(input logic [3:0] seq);
        q_m.push_back(seq);
        q_l.push_back(rev4(seq));
    endtask

    task automatic pop_check(input string name);
        total++;
        if (q_m.size() == 0 || q_l.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            exp_m = q_m.pop_front();
            exp_l = q_l.pop_front();
            if ({m_pd, l_pd} !== {exp_m, exp_l}) begin
                bad++;
                $display("FAIL %s: got msb=%b lsb=%b want msb=%b lsb=%b", name, m_pd, l_pd, exp_m, exp_l);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = 1'b0; s_start = 1'b0; p_ready = 1'b0;
        #12;
        total++;
        if ({flags(), m_pd, l_pd} !== 14'b0) begin
            bad++;
            $display("FAIL reset: got %b want %b", {flags(), m_pd, l_pd}, 14'b0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        p_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        total++;
        if (flags() !== 6'b010_010) begin
            bad++; $display("FAIL basic_mid: got %b want %b", flags(), 6'b010_010);
        end
        push_word(4'b1011);
        step(1'b1, 1'b1, 1'b0);
        total++;
        if (flags() !== 6'b100_100) begin
            bad++; $display("FAIL basic_done: got %b want %b", flags(), 6'b100_100);
        end
        pop_check("basic_data");
        step(1'b0, 1'b0, 1'b0);
        total++;
        if ({m_pv, l_pv} !== 2'b00) begin
            bad++; $display("FAIL basic_consumed: got %b want %b", {m_pv, l_pv}, 2'b00);
        end
    endtask

    task automatic test_gaps();
        p_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int g = 0; g < 2; g++) begin
            step(1'b0, 1'b1, 1'b1);
            total++;
            if (flags() !== 6'b010_010) begin
                bad++; $display("FAIL gap%0d: got %b want %b", g, flags(), 6'b010_010);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        total++;
        if (flags() !== 6'b010_010) begin
            bad++; $display("FAIL gap_bit3: got %b want %b", flags(), 6'b010_010);
        end
        push_word(4'b1000);
        step(1'b1, 1'b0, 1'b0);
        total++;
        if (flags() !== 6'b100_100) begin
            bad++; $display("FAIL gap_done: got %b want %b", flags(), 6'b100_100);
        end
        pop_check("gap_data");
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] words [2];
        words[0] = 4'b0010;
        words[1] = 4'b0100;
        p_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            push_word(words[w]);
            for (int i = 0; i < 4; i++) step(1'b1, words[w][3-i], (i == 0));
            total++;
            if (flags() !== 6'b100_100) begin
                bad++; $display("FAIL b2b_flags%0d: got %b want %b", w, flags(), 6'b100_100);
            end
            pop_check("b2b_data");
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        logic [3:0] w2;
        w2 = 4'b0001;
        p_ready = 1'b0;
        push_word(4'b1000);
        for (int i = 0; i < 4; i++) step(1'b1, (i == 0), (i == 0));
        pop_check("ovr_first");
        for (int i = 0; i < 3; i++) step(1'b1, w2[3-i], (i == 0));
        total++;
        if (flags() !== 6'b110_110) begin
            bad++; $display("FAIL ovr_before: got %b want %b", flags(), 6'b110_110);
        end
        step(1'b1, w2[0], 1'b0);
        total++;
        if (flags() !== 6'b101_101) begin
            bad++; $display("FAIL ovr_set: got %b want %b", flags(), 6'b101_101);
        end
        total++;
        if ({m_pd, l_pd} !== {exp_m, exp_l}) begin
            bad++; $display("FAIL ovr_hold: got %b %b want %b %b", m_pd, l_pd, exp_m, exp_l);
        end
        p_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        total++;
        if (flags() !== 6'b001_001) begin
            bad++; $display("FAIL ovr_sticky: got %b want %b", flags(), 6'b001_001);
        end
    endtask

    task automatic test_restart();
        logic [5:0] seq;
        logic [5:0] stv;
        seq = 6'b11_0110;
        stv = 6'b10_1000;
        p_ready = 1'b1;
        push_word(4'b0110);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq[5-i], stv[5-i]);
            total++;
            if ({m_pv, m_busy, l_pv, l_busy} !== 4'b0101) begin
                bad++; $display("FAIL restart_slot%0d: got %b want %b", i, {m_pv, m_busy, l_pv, l_busy}, 4'b0101);
            end
        end
        step(1'b1, seq[0], stv[0]);
        total++;
        if ({m_pv, m_busy, l_pv, l_busy} !== 4'b1010) begin
            bad++; $display("FAIL restart_done: got %b want %b", {m_pv, m_busy, l_pv, l_busy}, 4'b1010);
        end
        pop_check("restart_data");
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [3:0] w;
        w = 4'b1101;
        p_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        s_valid = 1'b0; s_start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({flags(), m_pd, l_pd} !== 14'b0) begin
            bad++; $display("FAIL async_rst: got %b want %b", {flags(), m_pd, l_pd}, 14'b0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        push_word(w);
        for (int i = 0; i < 4; i++) step(1'b1, w[3-i], (i == 0));
        total++;
        if (flags() !== 6'b100_100) begin
            bad++; $display("FAIL post_rst_flags: got %b want %b", flags(), 6'b100_100);
        end
        pop_check("post_rst_data");
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_overrun();
        test_restart();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
